// File: rtl/mem_arbiter_pkg.sv
// Shared constants for mem_arbiter: FSM encodings, owner encodings, size defaults.
package mem_arbiter_pkg;

  localparam int unsigned DEF_WORD_SIZE  = 32;
  localparam int unsigned DEF_BLOCK_SIZE = 8;
  localparam int unsigned DEF_MEM_SIZE   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache miss paths onto one block-wide backing memory.
// Tie policy: MEM_ARB_RR_EN defined -> round-robin, otherwise D-cache wins ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int unsigned WORD_SIZE  = DEF_WORD_SIZE,
  parameter  int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter  int unsigned MEM_SIZE   = DEF_MEM_SIZE,
  localparam int unsigned BW         = WORD_SIZE * BLOCK_SIZE,
  localparam int unsigned AW         = $clog2(MEM_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [BW-1:0] i_data,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [BW-1:0] d_wdata,
  output logic          d_ready,
  output logic [BW-1:0] d_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [BW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [BW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  state_t        state, state_nxt;
  logic          win;
  logic          owner_nxt;
  logic          mem_ren_nxt, mem_wen_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [BW-1:0] mem_wdata_nxt;
  logic          i_ready_nxt, d_ready_nxt;
  logic [BW-1:0] i_data_nxt, d_rdata_nxt;
  logic          busy_nxt;
`ifdef MEM_ARB_RR_EN
  logic          rr_prio, rr_prio_nxt;
`endif

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    mem_ren_nxt   = mem_ren;
    mem_wen_nxt   = mem_wen;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    i_ready_nxt   = 1'b0;
    d_ready_nxt   = 1'b0;
    i_data_nxt    = i_data;
    d_rdata_nxt   = d_rdata;
    win           = OWN_I;
`ifdef MEM_ARB_RR_EN
    rr_prio_nxt   = rr_prio;
`endif

    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      win = rr_prio;
`else
      win = OWN_D;
`endif
    end else if (d_req) begin
      win = OWN_D;
    end

    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          owner_nxt = win;
          state_nxt = WAIT;
`ifdef MEM_ARB_RR_EN
          rr_prio_nxt = ~win;
`endif
          if (win == OWN_D) begin
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            mem_ren_nxt   = ~d_we;
            mem_wen_nxt   = d_we;
          end else begin
            mem_addr_nxt  = i_addr;
            mem_ren_nxt   = 1'b1;
            mem_wen_nxt   = 1'b0;
          end
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nxt   = RESP;
          mem_ren_nxt = 1'b0;
          mem_wen_nxt = 1'b0;
          if (owner == OWN_D) begin
            d_ready_nxt = 1'b1;
            if (mem_ren) d_rdata_nxt = mem_rdata;
          end else begin
            i_ready_nxt = 1'b1;
            i_data_nxt  = mem_rdata;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_data    <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_prio   <= OWN_I;
`endif
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      mem_ren   <= mem_ren_nxt;
      mem_wen   <= mem_wen_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      i_ready   <= i_ready_nxt;
      d_ready   <= d_ready_nxt;
      i_data    <= i_data_nxt;
      d_rdata   <= d_rdata_nxt;
      busy      <= busy_nxt;
`ifdef MEM_ARB_RR_EN
      rr_prio   <= rr_prio_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-delay block memory model.
// Tie-order expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned BW    = DEF_WORD_SIZE * DEF_BLOCK_SIZE;
  localparam int unsigned AW    = $clog2(DEF_MEM_SIZE);
  localparam int          DELAY = 15;
  localparam int          TMO   = 400;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ready;
  logic [BW-1:0] i_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [BW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [BW-1:0] d_rdata;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_ready;
  logic [BW-1:0] mem_rdata;
  logic          owner, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic          own;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] data;
  } exp_t;
  exp_t sbq[$];
  logic m_prio = OWN_I;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [BW-1:0] pat(input int a);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(a);
    return {DEF_BLOCK_SIZE{w}};
  endfunction

  // Memory model: ready pulses after DELAY enabled cycles; counter restarts whenever enables drop
  logic [BW-1:0] mem [DEF_MEM_SIZE];
  int            mcnt = 0;
  logic          mdone = 1'b0, mdl_ready = 1'b0, spur = 1'b0;
  logic [BW-1:0] mdl_rdata = '0;
  assign mem_ready = mdl_ready | spur;
  assign mem_rdata = mdl_rdata;

  initial for (int k = 0; k < int'(DEF_MEM_SIZE); k++) mem[k] = pat(k);

  always @(posedge clock) begin
    if (!(mem_ren || mem_wen)) begin
      mcnt <= 0; mdone <= 1'b0; mdl_ready <= 1'b0;
    end else if (!mdone) begin
      if (mcnt == DELAY - 1) begin
        mdl_ready <= 1'b1;
        mdone     <= 1'b1;
        mdl_rdata <= mem[mem_addr];
        if (mem_wen) mem[mem_addr] <= mem_wdata;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mdl_ready <= 1'b0;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic own, input logic [AW-1:0] a, input logic we, input logic [BW-1:0] data);
    exp_t e;
    e.own = own; e.addr = a; e.we = we; e.data = data;
    sbq.push_back(e);
    m_prio = ~own;
  endtask

  function automatic logic tie_winner();
`ifdef MEM_ARB_RR_EN
    return m_prio;
`else
    return OWN_D;
`endif
  endfunction

  // Monitor: checks each grant against the queue head, pops on every ready pulse
  logic prev_en = 1'b0;
  int   lowrun  = 2;
  int   start   = 0;
  always @(negedge clock) begin
    exp_t e;
    logic en;
    if (!reset) begin
      prev_en = 1'b0;
      lowrun  = 2;
    end else begin
      en = mem_ren | mem_wen;
      if (en && !prev_en) begin
        chk1("enable_low_gap", lowrun >= 2, 1'b1);
        start  = cyc;
        lowrun = 0;
        chk1("grant_expected", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
          e = sbq[0];
          chk1("grant_owner", owner, e.own);
          chkw("grant_addr", BW'(mem_addr), BW'(e.addr));
          chk1("grant_wen", mem_wen, e.we);
          chk1("grant_ren", mem_ren, ~e.we);
          chk1("grant_busy", busy, 1'b1);
          if (e.we) chkw("grant_wdata", mem_wdata, e.data);
        end
      end
      if (!en) lowrun++;
      if (i_ready || d_ready) begin
        chk1("ready_expected", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk1("i_ready_sel", i_ready, ~e.own);
          chk1("d_ready_sel", d_ready, e.own);
          chki("ready_latency", cyc - start, DELAY + 1);
          if (!e.we) chkw("read_data", (e.own == OWN_D) ? d_rdata : i_data, e.data);
        end
      end
      prev_en = en;
    end
  end

  task automatic i_access(input logic [AW-1:0] a);
    logic got;
    got = 1'b0;
    @(negedge clock);
    i_req = 1'b1; i_addr = a;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clock);
      if (i_ready) begin got = 1'b1; break; end
    end
    i_req = 1'b0;
    chk1("i_wait_bound", got, 1'b1);
  endtask

  task automatic d_access(input logic we, input logic [AW-1:0] a, input logic [BW-1:0] wd);
    logic got;
    got = 1'b0;
    @(negedge clock);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clock);
      if (d_ready) begin got = 1'b1; break; end
    end
    d_req = 1'b0;
    chk1("d_wait_bound", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] wx;
    int ni, nd, ki, kd;
    logic w;
    wx = {DEF_BLOCK_SIZE{32'h5A5A_0303}};

    repeat (3) @(negedge clock);
    chk1("rst_mem_ren", mem_ren, 1'b0);
    chk1("rst_mem_wen", mem_wen, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_i_ready", i_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chkw("rst_i_data", i_data, '0);
    chkw("rst_d_rdata", d_rdata, '0);
    chkw("rst_mem_addr", BW'(mem_addr), '0);
    reset = 1'b1;

    // Single I fill of block 5
    push(OWN_I, AW'(5), 1'b0, pat(5));
    i_access(AW'(5));

    // D write-back of block 3, then read it back
    push(OWN_D, AW'(3), 1'b1, wx);
    d_access(1'b1, AW'(3), wx);
    push(OWN_D, AW'(3), 1'b0, wx);
    d_access(1'b0, AW'(3), '0);
    chkw("i_data_hold", i_data, pat(5));

    // Stray mem_ready while idle must be ignored
    @(negedge clock); spur = 1'b1;
    @(negedge clock); spur = 1'b0;
    chk1("spur_busy", busy, 1'b0);
    chk1("spur_i_ready", i_ready, 1'b0);
    chk1("spur_d_ready", d_ready, 1'b0);

    // Simultaneous requests
    w = tie_winner();
    if (w == OWN_D) begin
      push(OWN_D, AW'(11), 1'b0, pat(11));
      push(OWN_I, AW'(10), 1'b0, pat(10));
    end else begin
      push(OWN_I, AW'(10), 1'b0, pat(10));
      push(OWN_D, AW'(11), 1'b0, pat(11));
    end
    fork
      i_access(AW'(10));
      d_access(1'b0, AW'(11), '0);
    join
    chkw("d_rdata_hold", d_rdata, pat(11));

    // Both requesters re-requesting back to back
    ni = 2; nd = 2; ki = 0; kd = 0;
    while (ni > 0 || nd > 0) begin
      if (ni > 0 && nd > 0) w = tie_winner();
      else w = (nd > 0) ? OWN_D : OWN_I;
      if (w == OWN_D) begin
        push(OWN_D, AW'(22 + kd), 1'b0, pat(22 + kd)); kd++; nd--;
      end else begin
        push(OWN_I, AW'(20 + ki), 1'b0, pat(20 + ki)); ki++; ni--;
      end
    end
    fork
      begin i_access(AW'(20)); i_access(AW'(21)); end
      begin d_access(1'b0, AW'(22), '0); d_access(1'b0, AW'(23), '0); end
    join

    // Reset in the middle of a WAIT
    push(OWN_I, AW'(7), 1'b0, pat(7));
    @(negedge clock); i_req = 1'b1; i_addr = AW'(7);
    repeat (6) @(negedge clock);
    chk1("busy_before_reset", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk1("midrst_mem_ren", mem_ren, 1'b0);
    chk1("midrst_mem_wen", mem_wen, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_i_ready", i_ready, 1'b0);
    chk1("midrst_d_ready", d_ready, 1'b0);
    i_req = 1'b0;
    sbq.delete(0);
    m_prio = OWN_I;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    push(OWN_I, AW'(8), 1'b0, pat(8));
    i_access(AW'(8));

    // Consecutive I fills, each must take the full memory delay
    push(OWN_I, AW'(1), 1'b0, pat(1));
    push(OWN_I, AW'(2), 1'b0, pat(2));
    i_access(AW'(1));
    i_access(AW'(2));

    repeat (5) @(negedge clock);
    chki("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
